// File: rtl/bnn_param_loader.sv
// bnn_param_loader
// ----------------
// Serial parameter loader for a daisy-chained BNN neuron layer. Bytes arrive
// over a valid/ready handshake. Each byte is shifted MSB-first onto the
// chain's setup/param_in inputs. The load stops after exactly CHAIN_BITS
// shifts, so every neuron's weights and bias registers end up loaded
// deterministically.
//
// Optional feature (macro BNN_LOADER_READBACK_EN):
//   While a load is shifting, chain_out is captured MSB-first into bytes.
//   Each completed byte appears on rb_data, and rb_valid pulses for one
//   cycle. A partial final byte is emitted left-aligned and zero-padded.
//   The net effect is that a new load streams out the previous chain
//   contents in their original send order.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   reset      in   asynchronous active-high reset
//   start      in   single-cycle pulse: begin / restart / abort a load
//   in_data    in   parameter byte
//   in_valid   in   in_data valid
//   in_ready   out  byte accepted when in_valid && in_ready
//   setup      out  neuron setup enable (one chain shift per cycle)
//   param_in   out  serial bit into the first neuron
//   chain_out  in   param_out of the last neuron (readback only)
//   busy       out  load in progress
//   done       out  load complete, held until start or reset
//   bit_count  out  bits shifted in the current load (saturating)
//   rb_data    out  readback byte          (BNN_LOADER_READBACK_EN only)
//   rb_valid   out  readback byte strobe   (BNN_LOADER_READBACK_EN only)

module bnn_param_loader #(
    parameter int unsigned NEURONS    = 2,
    parameter int unsigned INPUTS     = 8,
    parameter int unsigned BIAS_BITS  = 3,
    parameter int unsigned CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS),
    parameter int unsigned CNT_W      = $clog2(CHAIN_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             setup,
    output logic             param_in,
    input  logic             chain_out,
`ifdef BNN_LOADER_READBACK_EN
    output logic [7:0]       rb_data,
    output logic             rb_valid,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {StIdle, StWait, StShift, StDone} state_t;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(CHAIN_BITS - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(CHAIN_BITS);

    state_t           state;
    logic [7:0]       shreg;
    logic [3:0]       bits_left;
    logic [CNT_W-1:0] bit_count_q;

    logic last_bit;
    assign last_bit = (bit_count_q == LastIdx);

`ifdef BNN_LOADER_READBACK_EN
    logic [7:0] rb_shreg;
    logic [2:0] rb_cnt;
    logic [7:0] rb_next;

    // Byte as it stands once this cycle's chain_out bit has been captured.
    always_comb begin
        rb_next = {rb_shreg[6:0], chain_out};
    end
`else
    // chain_out has no function without readback.
    logic unused_chain_out;
    assign unused_chain_out = chain_out;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            shreg       <= 8'h00;
            bits_left   <= 4'd0;
            bit_count_q <= '0;
`ifdef BNN_LOADER_READBACK_EN
            rb_shreg    <= 8'h00;
            rb_cnt      <= 3'd0;
            rb_data     <= 8'h00;
            rb_valid    <= 1'b0;
`endif
        end else begin
`ifdef BNN_LOADER_READBACK_EN
            rb_valid <= 1'b0;
`endif
            if (start) begin
                // Begin, restart or abort. The in-flight byte is dropped,
                // and start wins over a same-cycle handshake.
                state       <= StWait;
                shreg       <= 8'h00;
                bits_left   <= 4'd0;
                bit_count_q <= '0;
`ifdef BNN_LOADER_READBACK_EN
                rb_shreg    <= 8'h00;
                rb_cnt      <= 3'd0;
`endif
            end else begin
                unique case (state)
                    StIdle, StDone: ;
                    StWait: begin
                        if (in_valid) begin
                            shreg     <= in_data;
                            bits_left <= 4'd8;
                            state     <= StShift;
                        end
                    end
                    StShift: begin
                        shreg     <= {shreg[6:0], 1'b0};
                        bits_left <= bits_left - 4'd1;
                        if (bit_count_q != FullCnt) begin
                            bit_count_q <= bit_count_q + 1'b1;
                        end
                        // The last chain bit wins over the end of a byte.
                        // Unsent bits of a truncated byte are discarded.
                        if (last_bit) begin
                            state <= StDone;
                        end else if (bits_left == 4'd1) begin
                            state <= StWait;
                        end
`ifdef BNN_LOADER_READBACK_EN
                        rb_shreg <= rb_next;
                        rb_cnt   <= rb_cnt + 3'd1;
                        if (rb_cnt == 3'd7) begin
                            rb_data  <= rb_next;
                            rb_valid <= 1'b1;
                        end else if (last_bit) begin
                            // Left-align the partial byte, zero-padded.
                            rb_data  <= rb_next << (3'd7 - rb_cnt);
                            rb_valid <= 1'b1;
                            rb_cnt   <= 3'd0;
                        end
`endif
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    // Decoded directly from state so the neurons see setup/param_in on the
    // same edge the loader advances; reset drops them immediately.
    assign setup     = (state == StShift);
    assign param_in  = (state == StShift) & shreg[7];
    assign in_ready  = (state == StWait) & ~start;
    assign busy      = (state == StWait) | (state == StShift);
    assign done      = (state == StDone);
    assign bit_count = bit_count_q;

endmodule
